key_event_encoder: RTL and testbench

Consumes the debounced key-state vector from the key debouncer and turns level changes into a stream of discrete press/release events. A round-robin scanner compares each key against a held "last reported" state and pushes one event per detected change into a small FWFT FIFO. The FIFO drains through a valid/ready handshake to the host-side report/SPI logic.

---
 rtl/key_event_encoder.sv | 118 +++++++++++
 tb/tb_key_event_encoder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/key_event_encoder.sv
// key_event_encoder
//   Turns the debounced key-level vector into a stream of press/release
//   events. A round-robin scanner compares one key per cycle against the
//   last state it reported. Each detected change pushes one event into a
//   first-word-fall-through FIFO, which drains through a valid/ready
//   handshake.
//
//   Optional feature macro: KEY_EVENT_TIMESTAMP_EN
//     When this macro is defined, each event carries a 16-bit free-running
//     cycle timestamp. The timestamp is taken in the cycle the event is
//     pushed.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_i          asynchronous active-high reset
//   keys_i         debounced key levels (1 = released, 0 = pressed)
//   event_valid_o  FIFO head holds an event
//   event_ready_i  consumer takes the head this cycle
//   event_data_o   [{ts[15:0],} pressed, key_index]
//   fifo_count_o   queued events, 0 .. 2^FIFO_AW
//   scan_idx_o     current scanner index (debug)
module key_event_encoder #(
    parameter int KEYS    = 61,
    parameter int IDX_W   = 6,
    parameter int FIFO_AW = 4,
`ifdef KEY_EVENT_TIMESTAMP_EN
    localparam int DATA_W = IDX_W + 17
`else
    localparam int DATA_W = IDX_W + 1
`endif
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [KEYS-1:0]    keys_i,
    output logic               event_valid_o,
    input  logic               event_ready_i,
    output logic [DATA_W-1:0]  event_data_o,
    output logic [FIFO_AW:0]   fifo_count_o,
    output logic [IDX_W-1:0]   scan_idx_o
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEYS - 1);

    logic [KEYS-1:0]    known_q;
    logic [IDX_W-1:0]   scan_idx_q;
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic               cur_key;
    logic               diff, full, push, pop;
    logic [DATA_W-1:0]  push_data;
    logic [IDX_W-1:0]   next_idx;

`ifdef KEY_EVENT_TIMESTAMP_EN
    logic [15:0] ts_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ts_q <= '0;
        else       ts_q <= ts_q + 16'd1;
    end

    assign push_data = {ts_q, ~cur_key, scan_idx_q};
`else
    assign push_data = {~cur_key, scan_idx_q};
`endif

    // Full is judged on the registered count only, so a pop in the same
    // cycle does not open a slot for the scanner.
    assign cur_key  = keys_i[scan_idx_q];
    assign diff     = cur_key != known_q[scan_idx_q];
    assign full     = count_q == FULL_CNT;
    assign push     = diff && !full;
    assign pop      = event_valid_o && event_ready_i;
    assign next_idx = (scan_idx_q == LAST_IDX) ? '0 : scan_idx_q + IDX_W'(1);

    // The scanner holds on a change it cannot queue, so no change is lost.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            known_q    <= '1;
            scan_idx_q <= '0;
        end else if (push) begin
            known_q[scan_idx_q] <= cur_key;
            scan_idx_q          <= next_idx;
        end else if (!diff) begin
            scan_idx_q <= next_idx;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (FIFO_AW + 1)'(1);
                2'b01:   count_q <= count_q - (FIFO_AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; the output is masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign event_valid_o = count_q != '0;
    assign event_data_o  = event_valid_o ? mem_q[rd_ptr_q] : '0;
    assign fifo_count_o  = count_q;
    assign scan_idx_o    = scan_idx_q;

endmodule

// File: tb/tb_key_event_encoder.sv
module tb_key_event_encoder;

    localparam int KEYS = 61;
`ifdef KEY_EVENT_TIMESTAMP_EN
    localparam int DW = 23;
`else
    localparam int DW = 7;
`endif

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic [KEYS-1:0] keys_i = '1;
    logic            event_valid_o;
    logic            event_ready_i = 1'b0;
    logic [DW-1:0]   event_data_o;
    logic [4:0]      fifo_count_o;
    logic [5:0]      scan_idx_o;

    key_event_encoder dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .keys_i        (keys_i),
        .event_valid_o (event_valid_o),
        .event_ready_i (event_ready_i),
        .event_data_o  (event_data_o),
        .fifo_count_o  (fifo_count_o),
        .scan_idx_o    (scan_idx_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: a queue of pending events plus the reported state.
    bit          m_known [KEYS];
    int          m_idx;
    int          m_ts;
    logic [31:0] m_q [$];
    logic [31:0] seen [$];   // events the DUT handed to the consumer

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_known[i]) m_known[i] = 1'b1;
        m_idx = 0;
        m_ts  = 0;
        m_q.delete();
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        model_reset();
        #1;
        chk("rst_valid", 32'(event_valid_o), 0);
        chk("rst_count", 32'(fifo_count_o), 0);
        chk("rst_data",  32'(event_data_o), 0);
        chk("rst_idx",   32'(scan_idx_o), 0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    // One clock: apply inputs, step the model on the edge, check after it.
    task automatic cycle(input logic [KEYS-1:0] k, input logic r);
        int          sz;
        logic [31:0] e;
        keys_i        = k;
        event_ready_i = r;
        #1;
        if (event_valid_o && event_ready_i) seen.push_back(32'(event_data_o));
        @(posedge clk_i);
        sz = m_q.size();
        if (sz != 0 && r) void'(m_q.pop_front());
        if (k[m_idx] != m_known[m_idx]) begin
            if (sz < 16) begin
                e = (32'(!k[m_idx]) << 6) | 32'(m_idx);
`ifdef KEY_EVENT_TIMESTAMP_EN
                e = e | (32'(m_ts & 16'hFFFF) << 7);
`endif
                m_q.push_back(e);
                m_known[m_idx] = k[m_idx];
                m_idx = (m_idx + 1) % KEYS;
            end
        end else begin
            m_idx = (m_idx + 1) % KEYS;
        end
        m_ts++;
        #1;
        chk("valid", 32'(event_valid_o), 32'(m_q.size() != 0));
        chk("count", 32'(fifo_count_o), 32'(m_q.size()));
        chk("scan_idx", 32'(scan_idx_o), 32'(m_idx));
        if (m_q.size() != 0) chk("data", 32'(event_data_o), m_q[0]);
    endtask

    initial begin
        logic [KEYS-1:0] k;
        bit              hit;
        k = '1;
        @(negedge clk_i);
        do_reset();

        // idle scan: no events, index wraps through 0..60
        for (int i = 0; i < 200; i++) cycle(k, 1'b1);

        // single press then release of key 5
        seen.delete();
        k[5] = 1'b0;
        for (int i = 0; i < 70; i++) cycle(k, 1'b1);
        chk("press5_n", 32'(seen.size()), 1);
        if (seen.size() > 0) chk("press5_ev", seen[0] & 32'h7F, 32'h45);
        seen.delete();
        k[5] = 1'b1;
        for (int i = 0; i < 200; i++) cycle(k, 1'b1);
        chk("rel5_n", 32'(seen.size()), 1);
        if (seen.size() > 0) chk("rel5_ev", seen[0] & 32'h7F, 32'h05);

        // fill to full, stall at index 16, then pop-without-push and refill
        seen.delete();
        for (int i = 0; i < 20; i++) k[i] = 1'b0;
        for (int i = 0; i < 80; i++) cycle(k, 1'b0);
        chk("sat_count", 32'(fifo_count_o), 16);
        chk("stall_idx", 32'(scan_idx_o), 16);
        cycle(k, 1'b1);
        chk("pop_only", 32'(fifo_count_o), 15);
        cycle(k, 1'b0);
        chk("refill", 32'(fifo_count_o), 16);
        for (int i = 0; i < 100; i++) cycle(k, 1'b1);
        chk("burst_n", 32'(seen.size()), 20);
        for (int i = 0; i < 20 && i < seen.size(); i++)
            chk("burst_ev", seen[i] & 32'h7F, 32'h40 | 32'(i));
        k = '1;
        for (int i = 0; i < 150; i++) cycle(k, 1'b1);

        // wrap ordering: key 60 then key 0 with the scan near the top
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            if (m_idx == 57) hit = 1'b1;
            else cycle(k, 1'b1);
        end
        chk("reach57", 32'(hit), 1);
        seen.delete();
        k[60] = 1'b0;
        cycle(k, 1'b1);
        cycle(k, 1'b1);
        k[0] = 1'b0;
        for (int i = 0; i < 70; i++) cycle(k, 1'b1);
        chk("wrap_n", 32'(seen.size()), 2);
        if (seen.size() > 1) begin
            chk("wrap_ev0", seen[0] & 32'h7F, 32'h7C);
            chk("wrap_ev1", seen[1] & 32'h7F, 32'h40);
        end
        k = '1;
        for (int i = 0; i < 150; i++) cycle(k, 1'b1);

        // reset with 8 queued events, key 3 still held afterwards
        for (int i = 0; i < 8; i++) k[i] = 1'b0;
        for (int i = 0; i < 70; i++) cycle(k, 1'b0);
        chk("pre_rst_count", 32'(fifo_count_o), 8);
        k = '1;
        k[3] = 1'b0;
        keys_i = k;
        do_reset();
        seen.delete();
        for (int i = 0; i < 70; i++) cycle(k, 1'b1);
        chk("rerep_n", 32'(seen.size()), 1);
        if (seen.size() > 0) begin
            chk("rerep_ev", seen[0] & 32'h7F, 32'h43);
`ifdef KEY_EVENT_TIMESTAMP_EN
            chk("rerep_ts", seen[0] >> 7, 3);
`endif
        end

        // random traffic, with phases of low ready so the FIFO fills
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) k[$urandom_range(0, KEYS - 1)] ^= 1'b1;
            cycle(k, $urandom_range(0, 99) < (((i / 500) % 2 == 1) ? 15 : 80));
        end
        k = '1;
        for (int i = 0; i < 200; i++) cycle(k, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
